// File: rtl/wb_vbuf_flip.sv
// Double-buffer page-flip controller for the two video color buffers.
// Wishbone B3 register slave; flips are applied at the start of vsync only.
module wb_vbuf_flip #(
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_cyc,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [31:0] bus_adr,
    input  logic [3:0]  bus_sel,
    input  logic [31:0] bus_dat_m2s,
    input  logic [2:0]  bus_cti,
    output logic [31:0] bus_dat_s2m,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        bus_rty,
    input  logic        vsync,
    output logic        display_sel,
    output logic        draw_sel,
    output logic        irq
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   vs_meta_q, vs_meta_d;
    logic                   vs_sync_q, vs_sync_d;
    logic                   vs_hist_q, vs_hist_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic                   disp_q, disp_d;
    logic                   done_q, done_d;
    logic                   irq_en_q, irq_en_d;
    logic                   auto_q, auto_d;
    logic                   irq_q, irq_d;
    logic [CNT_WIDTH-1:0]   frames_q, frames_d;

    logic        vs_start;
    logic        req;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        flip_wr;
    logic        toggle;
    logic [31:0] rdata;
    logic        unused_ok;

    // Bus decode, read mux and vsync edge detect.
    always_comb begin
        vs_start = vs_hist_q & ~vs_sync_q;
        req      = bus_cyc & bus_stb & ~ack_q;
        wr       = req & bus_we & bus_sel[0];
        wr_ctrl  = wr & (bus_adr[3:2] == 2'd0);
        wr_stat  = wr & (bus_adr[3:2] == 2'd1);
        flip_wr  = wr_ctrl & bus_dat_m2s[0];
        toggle   = vs_start & (auto_q | (state_q == S_PEND));
        rdata    = 32'd0;
        case (bus_adr[3:2])
            2'd0:    rdata = {29'd0, auto_q, irq_en_q, 1'b0};
            2'd1:    rdata = {29'd0, done_q, state_q == S_PEND, disp_q};
            2'd2:    rdata = 32'(frames_q);
            default: rdata = 32'd0;
        endcase
    end

    // Next-state for flip FSM, registers, bus handshake and synchronizer.
    always_comb begin
        vs_meta_d = vsync;
        vs_sync_d = vs_meta_q;
        vs_hist_d = vs_sync_q;
        ack_d     = req;
        dat_d     = req ? rdata : 32'd0;
        state_d   = state_q;
        disp_d    = disp_q;
        done_d    = done_q;
        irq_en_d  = irq_en_q;
        auto_d    = auto_q;
        frames_d  = frames_q;
        irq_d     = done_q & irq_en_q;
        if (wr_ctrl) begin
            irq_en_d = bus_dat_m2s[1];
            auto_d   = bus_dat_m2s[2];
        end
        if (wr_stat && bus_dat_m2s[2]) begin
            done_d = 1'b0;
        end
        if (vs_start) begin
            frames_d = frames_q + 1'b1;
            // A request arriving with vs_start waits for the next frame,
            // unless an older one is consumed now; then it is dropped.
            state_d  = (flip_wr && state_q == S_IDLE) ? S_PEND : S_IDLE;
        end else if (flip_wr) begin
            state_d = S_PEND;
        end
        if (toggle) begin
            disp_d = ~disp_q;
            done_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_hist_q <= 1'b1;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            disp_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            auto_q    <= 1'b0;
            irq_q     <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            vs_meta_q <= vs_meta_d;
            vs_sync_q <= vs_sync_d;
            vs_hist_q <= vs_hist_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            disp_q    <= disp_d;
            done_q    <= done_d;
            irq_en_q  <= irq_en_d;
            auto_q    <= auto_d;
            irq_q     <= irq_d;
            frames_q  <= frames_d;
        end
    end

    assign bus_dat_s2m = dat_q;
    assign bus_ack     = ack_q;
    assign bus_err     = 1'b0;
    assign bus_rty     = 1'b0;
    assign display_sel = disp_q;
    assign draw_sel    = ~disp_q;
    assign irq         = irq_q;

    assign unused_ok = ^{bus_cti, bus_adr[31:4], bus_adr[1:0],
                         bus_sel[3:1], bus_dat_m2s[31:3]};

endmodule

// File: tb/tb_wb_vbuf_flip.sv
// Bench for wb_vbuf_flip: directed and random bus/vsync stimulus
// checked against a frame-level behavioural model.
module tb_wb_vbuf_flip;

    localparam int CW = 8;
    localparam int unsigned MASK = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dout = '0;
    logic [2:0]  cti = '0;
    logic [31:0] din;
    logic        ack, err, rty;
    logic        vsync = 1'b1;
    logic        disp, draw, irq;

    int n_vec = 0;
    int n_err = 0;

    bit          m_disp, m_pend, m_done, m_en, m_auto, m_irq;
    int unsigned m_frames;
    logic [31:0] q;

    wb_vbuf_flip #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .bus_cyc(cyc), .bus_stb(stb), .bus_we(we),
        .bus_adr(adr), .bus_sel(sel), .bus_dat_m2s(dout),
        .bus_cti(cti), .bus_dat_s2m(din), .bus_ack(ack),
        .bus_err(err), .bus_rty(rty), .vsync(vsync),
        .display_sel(disp), .draw_sel(draw), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] r);
        case (r)
            2'd0:    return {29'd0, m_auto, m_en, 1'b0};
            2'd1:    return {29'd0, m_done, m_pend, m_disp};
            2'd2:    return m_frames & MASK;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_disp = 0; m_pend = 0; m_done = 0;
        m_en = 0; m_auto = 0; m_irq = 0; m_frames = 0;
    endtask

    task automatic model_vsync(output bit tog);
        tog = 0;
        m_frames++;
        if (m_auto || m_pend) begin
            m_disp = ~m_disp;
            m_done = 1;
            tog = 1;
        end
        m_pend = 0;
    endtask

    task automatic model_write(input logic [1:0] r, input logic [31:0] d,
                               input logic [3:0] s, input bit tog,
                               input bit was_pend);
        if (!s[0]) return;
        if (r == 2'd0) begin
            m_en = d[1];
            m_auto = d[2];
            if (d[0] && !was_pend) m_pend = 1;
        end
        if (r == 2'd1 && d[2] && !tog) m_done = 0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_disp"}, {31'd0, disp}, {31'd0, m_disp});
        chk({tag, "_draw"}, {31'd0, draw}, {31'd0, ~m_disp});
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic drive_bus(input bit w, input logic [1:0] r,
                             input logic [31:0] d, input logic [3:0] s);
        cyc = 1; stb = 1; we = w;
        adr = $urandom();
        adr[3:2] = r;
        dout = d; sel = s;
        cti = 3'($urandom_range(0, 7));
    endtask

    task automatic release_bus();
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb(input bit w, input logic [1:0] r, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
        logic [31:0] exp;
        exp = m_read(r);
        drive_bus(w, r, d, s);
        cycle();
        chk("ack", {31'd0, ack}, 32'd1);
        rd = din;
        if (!w) chk("rdata", din, exp);
        release_bus();
        if (w) model_write(r, d, s, 0, m_pend);
        cycle();
        chk("ack_single", {31'd0, ack}, 32'd0);
        m_irq = m_done & m_en;
        chk_outs("post_wb");
    endtask

    task automatic do_vsync(input int low_extra, input bit w,
                            input logic [1:0] r, input logic [31:0] d,
                            input logic [3:0] s);
        bit tog, was_pend, prev_irq;
        vsync = 0;
        cycle();
        chk("vs_edge1", {31'd0, disp}, {31'd0, m_disp});
        cycle();
        chk("vs_edge2", {31'd0, disp}, {31'd0, m_disp});
        if (w) drive_bus(1'b1, r, d, s);
        cycle();
        if (w) begin
            chk("col_ack", {31'd0, ack}, 32'd1);
            release_bus();
        end
        prev_irq = m_irq;
        was_pend = m_pend;
        model_vsync(tog);
        if (w) model_write(r, d, s, tog, was_pend);
        chk("vs_edge3_disp", {31'd0, disp}, {31'd0, m_disp});
        chk("vs_edge3_draw", {31'd0, draw}, {31'd0, ~m_disp});
        chk("vs_edge3_irq", {31'd0, irq}, {31'd0, prev_irq});
        cycle();
        m_irq = m_done & m_en;
        chk("vs_irq", {31'd0, irq}, {31'd0, m_irq});
        repeat (low_extra) cycle();
        vsync = 1;
        repeat (3) cycle();
        chk_outs("post_vs");
    endtask

    task automatic vs_plain(input int low_extra);
        do_vsync(low_extra, 1'b0, 2'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        release_bus();
        vsync = 1;
        repeat (2) cycle();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", din, 32'd0);
        rst = 0;
        model_reset();
        chk_outs("rst");
    endtask

    initial begin
        int op;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_disp", {31'd0, disp}, 32'd0);
        chk("rst_draw", {31'd0, draw}, 32'd1);
        wb(0, 2'd1, 0, 4'h0, q);
        chk("rst_status", q, 32'h0);
        vs_plain(1);
        wb(0, 2'd2, 0, 4'h0, q);
        chk("frames_one", q, 32'h1);

        wb(1, 2'd0, 32'h3, 4'h1, q);
        wb(0, 2'd1, 0, 4'h0, q);
        chk("status_pend", q, 32'h2);
        vs_plain(2);
        chk("flip_disp", {31'd0, disp}, 32'd1);
        wb(0, 2'd1, 0, 4'h0, q);
        chk("status_done", q, 32'h5);
        wb(1, 2'd1, 32'h4, 4'h1, q);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        wb(1, 2'd0, 32'h3, 4'hF, q);
        wb(1, 2'd0, 32'h3, 4'hF, q);
        vs_plain(0);
        vs_plain(0);
        wb(1, 2'd0, 32'h3, 4'h0, q);
        vs_plain(0);

        do_vsync(0, 1'b1, 2'd0, 32'h3, 4'h1);
        wb(0, 2'd1, 0, 4'h0, q);
        chk("col_pend", q & 32'h2, 32'h2);
        vs_plain(0);
        wb(1, 2'd0, 32'h3, 4'h1, q);
        do_vsync(0, 1'b1, 2'd1, 32'h4, 4'h1);
        wb(0, 2'd1, 0, 4'h0, q);
        chk("col_done_kept", q & 32'h4, 32'h4);
        wb(1, 2'd0, 32'h3, 4'h1, q);
        do_vsync(1, 1'b1, 2'd0, 32'h3, 4'h1);

        wb(1, 2'd0, 32'h3, 4'h1, q);
        do_reset();
        vs_plain(0);
        chk("rst_lost_req", {31'd0, disp}, 32'd0);

        drive_bus(0, 2'd2, 0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("held_ack", {31'd0, ack}, {31'd0, (i % 2) == 0});
            if ((i % 2) == 0) chk("held_rd", din, m_frames & MASK);
        end
        release_bus();
        cycle();

        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: wb(1, 2'd0, $urandom(), 4'($urandom()), q);
                1: wb(1, 2'd1, $urandom(), 4'($urandom()), q);
                2: wb(0, 2'($urandom()), 0, 4'h0, q);
                default:
                    do_vsync(int'($urandom_range(0, 3)),
                             $urandom_range(0, 3) == 0,
                             2'($urandom_range(0, 1)), $urandom(),
                             4'($urandom()));
            endcase
        end

        do_reset();
        wb(1, 2'd0, 32'h4, 4'h1, q);
        for (int i = 0; i < MASK; i++) vs_plain(0);
        wb(0, 2'd2, 0, 4'h0, q);
        chk("frames_max", q, MASK);
        vs_plain(0);
        wb(0, 2'd2, 0, 4'h0, q);
        chk("frames_wrap", q, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
